// File: rtl/pll_lock_supervisor_pkg.sv
// rtl/pll_lock_supervisor_pkg.sv - shared state encoding and defaults for the PLL lock supervisor
package pll_lock_supervisor_pkg;

   typedef enum logic [1:0] {
      ST_RESET  = 2'd0,
      ST_WAIT   = 2'd1,
      ST_STABLE = 2'd2,
      ST_RUN    = 2'd3
   } state_t;

   localparam int PLL_RST_PULSE_DEF = 16;
   localparam int LOCK_STABLE_DEF   = 1024;
   localparam int LOCK_TIMEOUT_DEF  = 65536;

   // One shared phase counter serves all three waits, so it is sized for the longest.
   function automatic int cnt_width(input int a, input int b, input int c);
      int m;
      m = (a > b) ? a : b;
      m = (m > c) ? m : c;
      return (m > 1) ? $clog2(m) : 1;
   endfunction

endpackage

// File: rtl/reset_release_sync.sv
// rtl/reset_release_sync.sv - reset release chain: async clear, synchronous staged deassert
module reset_release_sync #(
   parameter int STAGES = 3
) (
   input  logic clk,
   input  logic rst_n,
   input  logic release_en,
   output logic resetn_out
);

   logic [STAGES-1:0] chain;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         chain <= '0;
      end else if (!release_en) begin
         chain <= '0;
      end else begin
         chain <= (chain << 1) | STAGES'(1);
      end
   end

   assign resetn_out = chain[STAGES-1];

endmodule

// File: rtl/pll_lock_supervisor.sv
// rtl/pll_lock_supervisor.sv - drives PLL reset, qualifies lock, releases downstream reset
module pll_lock_supervisor
   import pll_lock_supervisor_pkg::*;
#(
   parameter int RST_PULSE_CYCLES    = PLL_RST_PULSE_DEF,
   parameter int LOCK_STABLE_CYCLES  = LOCK_STABLE_DEF,
   parameter int LOCK_TIMEOUT_CYCLES = LOCK_TIMEOUT_DEF,
   parameter int RELEASE_STAGES      = 3,
   parameter int CNT_W               = 8
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             pll_lock,
   input  logic             soft_rst_req,
   output logic             pll_rst,
   output logic             sys_resetn,
   output logic             locked_ok,
   output logic [CNT_W-1:0] relock_cnt,
   output logic [CNT_W-1:0] timeout_cnt
);

   localparam int CW = cnt_width(RST_PULSE_CYCLES, LOCK_STABLE_CYCLES, LOCK_TIMEOUT_CYCLES);
   localparam logic [CW-1:0] RST_TC    = CW'(RST_PULSE_CYCLES - 1);
   localparam logic [CW-1:0] STABLE_TC = CW'(LOCK_STABLE_CYCLES - 1);
   localparam logic [CW-1:0] TIMEOUT_TC = CW'(LOCK_TIMEOUT_CYCLES - 1);

   state_t          state;
   logic [CW-1:0]   cnt;
   logic            lock_meta;
   logic            lock_s;
   logic            run_hold;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         lock_meta <= 1'b0;
         lock_s    <= 1'b0;
      end else begin
         lock_meta <= pll_lock;
         lock_s    <= lock_meta;
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state       <= ST_RESET;
         cnt         <= '0;
         pll_rst     <= 1'b1;
         locked_ok   <= 1'b0;
         relock_cnt  <= '0;
         timeout_cnt <= '0;
      end else if (soft_rst_req) begin
         state     <= ST_RESET;
         cnt       <= '0;
         pll_rst   <= 1'b1;
         locked_ok <= 1'b0;
      end else begin
         case (state)
            ST_RESET: begin
               if (cnt == RST_TC) begin
                  state   <= ST_WAIT;
                  cnt     <= '0;
                  pll_rst <= 1'b0;
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            ST_WAIT: begin
               // A lock seen on the timeout cycle still wins.
               if (lock_s) begin
                  state <= ST_STABLE;
                  cnt   <= '0;
               end else if (cnt == TIMEOUT_TC) begin
                  state   <= ST_RESET;
                  cnt     <= '0;
                  pll_rst <= 1'b1;
                  if (~&timeout_cnt) timeout_cnt <= timeout_cnt + CNT_W'(1);
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            ST_STABLE: begin
               if (!lock_s) begin
                  state <= ST_WAIT;
                  cnt   <= '0;
               end else if (cnt == STABLE_TC) begin
                  state     <= ST_RUN;
                  cnt       <= '0;
                  locked_ok <= 1'b1;
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            ST_RUN: begin
               if (!lock_s) begin
                  state     <= ST_RESET;
                  cnt       <= '0;
                  pll_rst   <= 1'b1;
                  locked_ok <= 1'b0;
                  if (~&relock_cnt) relock_cnt <= relock_cnt + CNT_W'(1);
               end
            end
            default: begin
               state     <= ST_RESET;
               cnt       <= '0;
               pll_rst   <= 1'b1;
               locked_ok <= 1'b0;
            end
         endcase
      end
   end

   // Chain only shifts while RUN persists, so leaving RUN clears it on the same edge.
   assign run_hold = (state == ST_RUN) && lock_s && !soft_rst_req;

   reset_release_sync #(
      .STAGES(RELEASE_STAGES)
   ) u_release (
      .clk       (clk),
      .rst_n     (resetn),
      .release_en(run_hold),
      .resetn_out(sys_resetn)
   );

endmodule
